// File: rtl/ysyx22041405_ifid_buf.sv
// IF/ID skid buffer: 2-entry in-order FIFO between fetch and decode.
// Define YSYX22041405_IFID_PERF_EN to add stall/bubble performance counters.
module ysyx22041405_ifid_buf #(
  parameter int               WIDTH    = 32,
  parameter logic [31:0]      RST_PC   = 32'h8000_0000,
  parameter logic [WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [WIDTH-1:0] in_inst,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [WIDTH-1:0] out_inst,
  input  logic             flush
`ifdef YSYX22041405_IFID_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic             wr_ptr, rd_ptr;
  logic [31:0]      mem_pc   [2];
  logic [WIDTH-1:0] mem_inst [2];
  logic [31:0]      last_pc;
  logic             push, pop;

  // Handshakes depend only on registered state, so no ready-to-ready path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_pc   = out_valid ? mem_pc[rd_ptr]   : last_pc;
  assign out_inst = out_valid ? mem_inst[rd_ptr] : NOP_INST;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE:     if (push & ~pop) state_nxt = FULL;
                 else if (pop & ~push) state_nxt = EMPTY;
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      last_pc <= RST_PC;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) begin
          rd_ptr  <= ~rd_ptr;
          last_pc <= mem_pc[rd_ptr];
        end
      end
    end
  end

  // Storage needs no reset: it is only observed through a non-empty state.
  always_ff @(posedge clk) begin
    if (push & ~flush) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_inst[wr_ptr] <= in_inst;
    end
  end

`ifdef YSYX22041405_IFID_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (out_valid & ~out_ready)          stall_cnt  <= stall_cnt + 32'd1;
      if (~out_valid & out_ready & ~flush) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx22041405_ifid_buf.sv
// Self-checking bench for ysyx22041405_ifid_buf: directed scenarios plus a
// randomized run against a queue-based model.
module tb_ysyx22041405_ifid_buf;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
`ifdef YSYX22041405_IFID_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ysyx22041405_ifid_buf dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .flush(flush)
`ifdef YSYX22041405_IFID_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic rdy);
    in_valid = 1; in_pc = pc; in_inst = pc ^ 32'h5a5a_0000; out_ready = rdy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
    total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL reset_pc got %h want %h", out_pc, RST_PC); end
    total++; if (out_inst !== NOP) begin bad++; $display("FAIL reset_inst got %h want %h", out_inst, NOP); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_stream();
    do_reset();
    push(RST_PC, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got %b want 0", out_valid); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== RST_PC + 32'(4*(i-1)))
        begin bad++; $display("FAIL stream_%0d got v=%b r=%b pc=%h want v=1 r=1 pc=%h",
          i, out_valid, in_ready, out_pc, RST_PC + 32'(4*(i-1))); end
      push(RST_PC + 32'(4*i), 1'b1);
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    push(32'h8000_0000, 1'b0);
    @(negedge clk);
    push(32'h8000_0004, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_pc !== 32'h8000_0000)
      begin bad++; $display("FAIL full_state got r=%b pc=%h want r=0 pc=80000000", in_ready, out_pc); end
    push(32'h8000_0008, 1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h8000_0000)
      begin bad++; $display("FAIL full_hold got r=%b v=%b pc=%h want r=0 v=1 pc=80000000", in_ready, out_valid, out_pc); end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0004 || in_ready !== 1'b1)
      begin bad++; $display("FAIL full_drain2 got v=%b pc=%h r=%b want v=1 pc=80000004 r=1", out_valid, out_pc, in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0004 || out_inst !== NOP)
      begin bad++; $display("FAIL full_empty got v=%b pc=%h inst=%h want v=0 pc=80000004 inst=%h", out_valid, out_pc, out_inst, NOP); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h8000_0000, 1'b0);
    @(negedge clk);
    push(32'h8000_0004, 1'b0);
    @(negedge clk);
    push(32'h8000_0010, 1'b0);
    flush = 1;
    @(negedge clk);
    idle();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== NOP || out_pc !== RST_PC)
      begin bad++; $display("FAIL flush got v=%b r=%b inst=%h pc=%h want v=0 r=1 inst=%h pc=%h",
        out_valid, in_ready, out_inst, out_pc, NOP, RST_PC); end
    out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got v=%b pc=%h want v=0", out_valid, out_pc); end
    end
    idle();
  endtask

  task automatic test_push_pop();
    do_reset();
    push(32'h8000_0000, 1'b0);
    @(negedge clk);
    push(32'h8000_0008, 1'b1);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0008 || out_inst !== (32'h8000_0008 ^ 32'h5a5a_0000))
      begin bad++; $display("FAIL push_pop got v=%b pc=%h inst=%h want v=1 pc=80000008", out_valid, out_pc, out_inst); end
    in_valid = 0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0008)
      begin bad++; $display("FAIL push_pop_last got v=%b pc=%h want v=0 pc=80000008", out_valid, out_pc); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h8000_0040, 1'b0);
    @(negedge clk);
    push(32'h8000_0044, 1'b0);
    @(negedge clk);
    idle();
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0000 || in_ready !== 1'b1)
      begin bad++; $display("FAIL async_reset got v=%b pc=%h r=%b want v=0 pc=80000000 r=1", out_valid, out_pc, in_ready); end
    #1 rst_n = 1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_empty got v=%b want 0", out_valid); end
    push(32'h8000_0020, 1'b1);
    @(negedge clk);
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0020)
      begin bad++; $display("FAIL async_reset_first got v=%b pc=%h want v=1 pc=80000020", out_valid, out_pc); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] qpc[$], qin[$];
    logic [31:0] last, epc, einst;
    logic        pu, po;
    do_reset();
    last = RST_PC;
    for (int i = 0; i < 400; i++) begin
      epc   = (qpc.size() != 0) ? qpc[0] : last;
      einst = (qpc.size() != 0) ? qin[0] : NOP;
      total++; if (out_valid !== (qpc.size() != 0) || in_ready !== (qpc.size() < 2) ||
                   out_pc !== epc || out_inst !== einst)
        begin bad++; $display("FAIL random_%0d got v=%b r=%b pc=%h inst=%h want v=%b r=%b pc=%h inst=%h",
          i, out_valid, in_ready, out_pc, out_inst, qpc.size() != 0, qpc.size() < 2, epc, einst); end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
      @(posedge clk);
      if (flush) begin
        qpc.delete(); qin.delete();
      end else begin
        pu = in_valid && qpc.size() < 2;
        po = out_ready && qpc.size() != 0;
        if (po) begin last = qpc.pop_front(); void'(qin.pop_front()); end
        if (pu) begin qpc.push_back(in_pc); qin.push_back(in_inst); end
      end
      @(negedge clk);
    end
    idle();
  endtask

`ifdef YSYX22041405_IFID_PERF_EN
  task automatic test_perf();
    do_reset();
    total++; if (stall_cnt !== 0 || bubble_cnt !== 0)
      begin bad++; $display("FAIL perf_reset got s=%0d b=%0d want 0 0", stall_cnt, bubble_cnt); end
    push(32'h8000_0000, 1'b0);
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(negedge clk);
    out_ready = 1;
    repeat (4) @(negedge clk);
    total++; if (stall_cnt !== 32'd5 || bubble_cnt !== 32'd3)
      begin bad++; $display("FAIL perf_counts got s=%0d b=%0d want 5 3", stall_cnt, bubble_cnt); end
    idle();
  endtask
`endif

  initial begin
    rst_n = 1;
    idle();
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_push_pop();
    test_async_reset();
    test_random();
`ifdef YSYX22041405_IFID_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
